// File: rtl/mult_sequencer.sv
// Keypad-driven control FSM for the signed multiplier: builds two signed decimal
// operands, launches the multiply, waits with a timeout and holds the product.
module mult_sequencer #(
    parameter int unsigned OP_W           = 8,
    parameter int unsigned MAX_DIGITS     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    input  logic                dat_ready,
    input  logic                signo,
    output logic                mult_start,
    output logic [OP_W-1:0]     mult_a,
    output logic [OP_W-1:0]     mult_b,
    input  logic                mult_ready,
    input  logic [2*OP_W-1:0]   mult_product,
    output logic [OP_W-1:0]     numero1_o,
    output logic [OP_W-1:0]     numero2_o,
    output logic [2*OP_W-1:0]   result,
    output logic                result_valid,
    output logic                busy,
    output logic                error,
    output logic [2:0]          state_o
);

    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [3:0]  KEY_CLEAR = 4'hC;

    typedef enum logic [2:0] {
        S_ENTER_A = 3'd0,
        S_ENTER_B = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_DONE    = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [OP_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]    digits_q, digits_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [OP_W-1:0]     op_a_q, op_a_d;
    logic [OP_W-1:0]     op_b_q, op_b_d;
    logic [2*OP_W-1:0]   result_d;
    logic                result_valid_d;
    logic                error_d;
    logic                dat_prev_q;

    logic                commit_c;
    logic                key_clear_c;
    logic                key_digit_c;
    logic [OP_W-1:0]     operand_c;
    logic [OP_W-1:0]     acc_x10_c;

    // Rising edge of the already-synchronized dat_ready level
    assign commit_c    = dat_ready & ~dat_prev_q;
    assign key_clear_c = key_valid && (key_code == KEY_CLEAR);
    assign key_digit_c = key_valid && (key_code <= 4'd9);
    assign acc_x10_c   = (acc_q << 3) + (acc_q << 1);
    assign operand_c   = signo ? (~acc_q + OP_W'(1)) : acc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_ENTER_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        digits_d       = digits_q;
        tmo_d          = tmo_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        result_d       = result;
        result_valid_d = result_valid;
        error_d        = error;

        unique case (state_q)
            S_ENTER_A, S_ENTER_B: begin
                // A commit edge takes precedence; a coincident key is dropped
                if (commit_c) begin
                    acc_d    = '0;
                    digits_d = '0;
                    if (state_q == S_ENTER_A) begin
                        op_a_d  = operand_c;
                        state_d = S_ENTER_B;
                    end else begin
                        op_b_d  = operand_c;
                        state_d = S_START;
                    end
                end else if (key_clear_c) begin
                    acc_d    = '0;
                    digits_d = '0;
                end else if (key_digit_c && (digits_q < CNT_W'(MAX_DIGITS))) begin
                    acc_d    = acc_x10_c + OP_W'(key_code);
                    digits_d = digits_q + CNT_W'(1);
                end
            end
            S_START: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mult_ready) begin
                    result_d       = mult_product;
                    result_valid_d = 1'b1;
                    state_d        = S_DONE;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    error_d = 1'b1;
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_DONE, S_ERR: begin
                if (commit_c || key_clear_c) begin
                    result_valid_d = 1'b0;
                    error_d        = 1'b0;
                    state_d        = S_ENTER_A;
                end
            end
            default: state_d = S_ENTER_A;
        endcase
    end

    // Datapath and registered Moore outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q        <= '0;
            digits_q     <= '0;
            tmo_q        <= '0;
            dat_prev_q   <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            error        <= 1'b0;
            mult_start   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            digits_q     <= digits_d;
            tmo_q        <= tmo_d;
            dat_prev_q   <= dat_ready;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            result       <= result_d;
            result_valid <= result_valid_d;
            error        <= error_d;
            mult_start   <= (state_d == S_START);
            busy         <= (state_d == S_START) || (state_d == S_WAIT);
        end
    end

    assign mult_a    = op_a_q;
    assign numero1_o = op_a_q;
    assign mult_b    = op_b_q;
    assign numero2_o = op_b_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: vector table, randomized operations
// against a digit-queue reference model, and hand-written corner sequences.
module tb_mult_sequencer;

    localparam int unsigned OP_W = 8;
    localparam int unsigned MAXD = 2;
    localparam int unsigned TMO  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              key_valid = 1'b0;
    logic [3:0]        key_code = 4'h0;
    logic              dat_ready = 1'b0;
    logic              signo = 1'b0;
    logic              mult_start;
    logic [OP_W-1:0]   mult_a, mult_b;
    logic              mult_ready = 1'b0;
    logic [2*OP_W-1:0] mult_product = '0;
    logic [OP_W-1:0]   numero1_o, numero2_o;
    logic [2*OP_W-1:0] result;
    logic              result_valid, busy, error;
    logic [2:0]        state_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_result = '0;

    mult_sequencer #(.OP_W(OP_W), .MAX_DIGITS(MAXD), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .dat_ready(dat_ready), .signo(signo), .mult_start(mult_start),
        .mult_a(mult_a), .mult_b(mult_b), .mult_ready(mult_ready),
        .mult_product(mult_product), .numero1_o(numero1_o), .numero2_o(numero2_o),
        .result(result), .result_valid(result_valid), .busy(busy), .error(error),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][3:0] ka;
        int              na;
        bit              sa;
        logic [3:0][3:0] kb;
        int              nb;
        bit              sb;
        logic [7:0]      ea;
        logic [7:0]      eb;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        key_code  = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        tick();
    endtask

    task automatic commit(input bit s);
        signo     = s;
        dat_ready = 1'b1;
        tick();
        dat_ready = 1'b0;
        tick();
    endtask

    // Reference: digits kept as a list, value formed positionally, then signed
    function automatic logic [7:0] model_operand(input logic [3:0][3:0] k, input int n, input bit s);
        int q[$];
        int val = 0;
        for (int i = 0; i < n; i++) begin
            if (k[3-i] <= 4'd9) begin
                if (q.size() < MAXD) q.push_back(int'(k[3-i]));
            end else if (k[3-i] == 4'hC) begin
                q.delete();
            end
        end
        for (int i = 0; i < q.size(); i++) val += q[i] * (10 ** (q.size() - 1 - i));
        return s ? 8'(-val) : 8'(val);
    endfunction

    // One full multiplication from ENTER_A, ending back in ENTER_A
    task automatic run_op(input logic [3:0][3:0] ka, input int na, input bit sa,
                          input logic [3:0][3:0] kb, input int nb, input bit sb,
                          input logic [7:0] ea, input logic [7:0] eb,
                          input int delay, input bit exit_clear);
        logic [15:0] prod;
        prod = 16'(int'($signed(ea)) * int'($signed(eb)));
        for (int i = 0; i < na; i++) press(ka[3-i]);
        commit(sa);
        chk("numero1_o", 32'(numero1_o), 32'(ea));
        chk("state_b", 32'(state_o), 32'd1);
        for (int i = 0; i < nb; i++) press(kb[3-i]);
        signo     = sb;
        dat_ready = 1'b1;
        tick();
        chk("start_pulse", 32'(mult_start), 32'd1);
        chk("state_start", 32'(state_o), 32'd2);
        chk("numero2_o", 32'(numero2_o), 32'(eb));
        dat_ready = 1'b0;
        tick();
        chk("start_once", 32'(mult_start), 32'd0);
        chk("busy_wait", 32'(busy), 32'd1);
        for (int i = 0; i < delay; i++) tick();
        chk("state_wait", 32'(state_o), 32'd3);
        mult_ready   = 1'b1;
        mult_product = prod;
        tick();
        mult_ready   = 1'b0;
        mult_product = 16'hDEAD;
        chk("result", 32'(result), 32'(prod));
        chk("result_valid", 32'(result_valid), 32'd1);
        chk("state_done", 32'(state_o), 32'd4);
        chk("mult_a_hold", 32'(mult_a), 32'(ea));
        chk("mult_b_hold", 32'(mult_b), 32'(eb));
        exp_result = prod;
        if (exit_clear) begin
            press(4'h5);
            chk("digit_in_done", 32'(state_o), 32'd4);
            press(4'hC);
        end else begin
            commit(1'b0);
        end
        chk("state_back", 32'(state_o), 32'd0);
        chk("rv_cleared", 32'(result_valid), 32'd0);
        chk("result_kept", 32'(result), 32'(prod));
    endtask

    initial begin
        vecs[0] = '{ka:{4'h4,4'h2,4'h0,4'h0}, na:2, sa:1'b0, kb:{4'h1,4'h5,4'h0,4'h0}, nb:2, sb:1'b1, ea:8'h2A, eb:8'hF1};
        vecs[1] = '{ka:{4'h9,4'h9,4'h7,4'h0}, na:3, sa:1'b1, kb:{4'h0,4'h0,4'h0,4'h0}, nb:1, sb:1'b1, ea:8'h9D, eb:8'h00};
        vecs[2] = '{ka:{4'h5,4'hC,4'h3,4'h0}, na:3, sa:1'b0, kb:{4'h9,4'h9,4'h0,4'h0}, nb:2, sb:1'b0, ea:8'h03, eb:8'h63};
        vecs[3] = '{ka:{4'h0,4'h0,4'h0,4'h0}, na:0, sa:1'b0, kb:{4'h7,4'h0,4'h0,4'h0}, nb:1, sb:1'b1, ea:8'h00, eb:8'hF9};
        vecs[4] = '{ka:{4'h0,4'h9,4'h0,4'h0}, na:2, sa:1'b1, kb:{4'h1,4'hA,4'h2,4'h0}, nb:3, sb:1'b0, ea:8'hF7, eb:8'h0C};
        vecs[5] = '{ka:{4'h9,4'h9,4'h0,4'h0}, na:2, sa:1'b0, kb:{4'h9,4'h9,4'h0,4'h0}, nb:2, sb:1'b1, ea:8'h63, eb:8'h9D};

        // Reset state
        tick();
        tick();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_num1", 32'(numero1_o), 32'd0);
        chk("rst_start", 32'(mult_start), 32'd0);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            run_op(vecs[v].ka, vecs[v].na, vecs[v].sa, vecs[v].kb, vecs[v].nb, vecs[v].sb,
                   vecs[v].ea, vecs[v].eb, 3, (v % 2) == 1);
        end

        // Randomized operations against the reference model
        for (int r = 0; r < 20; r++) begin
            logic [3:0][3:0] ka, kb;
            int na, nb;
            bit sa, sb;
            na = int'($urandom_range(0, 4));
            nb = int'($urandom_range(0, 4));
            sa = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
                ka[i] = 4'($urandom_range(0, 15));
                kb[i] = 4'($urandom_range(0, 15));
            end
            run_op(ka, na, sa, kb, nb, sb, model_operand(ka, na, sa), model_operand(kb, nb, sb),
                   int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)));
        end

        // dat_ready held high: a single advance
        press(4'h5);
        press(4'hC);
        press(4'h3);
        signo     = 1'b0;
        dat_ready = 1'b1;
        for (int i = 0; i < 50; i++) tick();
        chk("hold_num1", 32'(numero1_o), 32'h03);
        chk("hold_state", 32'(state_o), 32'd1);
        dat_ready = 1'b0;
        tick();

        // Timeout: ERR exactly TMO cycles after entering WAIT
        dat_ready = 1'b1;
        tick();
        dat_ready = 1'b0;
        tick();
        chk("tmo_wait_entry", 32'(state_o), 32'd3);
        for (int i = 0; i < int'(TMO) - 1; i++) tick();
        chk("tmo_not_yet", 32'(state_o), 32'd3);
        chk("tmo_err_low", 32'(error), 32'd0);
        tick();
        chk("tmo_state", 32'(state_o), 32'd5);
        chk("tmo_error", 32'(error), 32'd1);
        chk("tmo_rv", 32'(result_valid), 32'd0);
        chk("tmo_busy", 32'(busy), 32'd0);
        press(4'h6);
        mult_ready   = 1'b1;
        mult_product = 16'h5555;
        tick();
        mult_ready   = 1'b0;
        chk("err_digit_ignored", 32'(state_o), 32'd5);
        chk("err_ready_ignored", 32'(result), 32'(exp_result));
        commit(1'b0);
        chk("err_exit_state", 32'(state_o), 32'd0);
        chk("err_exit_error", 32'(error), 32'd0);

        // Key and commit edge in the same cycle: key dropped
        press(4'h3);
        key_code  = 4'h7;
        key_valid = 1'b1;
        signo     = 1'b0;
        dat_ready = 1'b1;
        tick();
        key_valid = 1'b0;
        dat_ready = 1'b0;
        tick();
        chk("coinc_num1", 32'(numero1_o), 32'h03);
        chk("coinc_state", 32'(state_o), 32'd1);
        mult_ready   = 1'b1;
        mult_product = 16'h1234;
        tick();
        mult_ready   = 1'b0;
        tick();
        chk("entb_ready_ignored", 32'(result), 32'(exp_result));
        chk("entb_state", 32'(state_o), 32'd1);
        press(4'h4);
        commit(1'b0);
        chk("coinc_num2", 32'(numero2_o), 32'h04);
        mult_ready   = 1'b1;
        mult_product = 16'h000C;
        tick();
        mult_ready   = 1'b0;
        chk("coinc_result", 32'(result), 32'h000C);
        exp_result = 16'h000C;
        press(4'hC);

        // Asynchronous reset in the middle of WAIT
        press(4'h1);
        commit(1'b0);
        press(4'h2);
        commit(1'b1);
        tick();
        chk("pre_rst_state", 32'(state_o), 32'd3);
        reset = 1'b1;
        #1;
        chk("arst_state", 32'(state_o), 32'd0);
        chk("arst_num1", 32'(numero1_o), 32'd0);
        chk("arst_num2", 32'(numero2_o), 32'd0);
        chk("arst_mult_a", 32'(mult_a), 32'd0);
        chk("arst_mult_b", 32'(mult_b), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rv", 32'(result_valid), 32'd0);
        #1;
        reset = 1'b0;
        tick();
        mult_ready   = 1'b1;
        mult_product = 16'hFFFE;
        tick();
        mult_ready   = 1'b0;
        chk("post_rst_state", 32'(state_o), 32'd0);
        chk("post_rst_result", 32'(result), 32'd0);
        chk("post_rst_rv", 32'(result_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
Control FSM that sequences the signed multiplier from keypad input.
- Builds two signed decimal operands from debounced key codes, one digit at a time.
- Commits each operand on a dat_ready rising edge, with the sign taken from signo.
- Starts the multiplier, waits for its ready pulse with a timeout, and holds the product for the display stage.
- Sits between the keypad decoder and the multiplier/display path inside top.

Parameters:
OP_W, 8, operand width in two's complement; constraint 10^MAX_DIGITS-1 <= 2^(OP_W-1)-1.
MAX_DIGITS, 2, maximum decimal digits per operand.
TIMEOUT_CYCLES, 1024, maximum cycles spent in WAIT before the error state.

Ports:
clk  in  1  system clock (27 MHz)
reset  in  1  asynchronous, active-high reset
key_valid  in  1  one-cycle pulse: key_code is valid
key_code  in  4  0-9 = digit, 0xC = clear, others ignored
dat_ready  in  1  level input, already synchronized; rising edge = commit/advance
signo  in  1  sign sampled at commit: 1 = negative
mult_start  out  1  one-cycle start pulse to the multiplier
mult_a  out  OP_W  operand A to the multiplier
mult_b  out  OP_W  operand B to the multiplier
mult_ready  in  1  one-cycle multiplier done pulse
mult_product  in  2*OP_W  signed product, valid while mult_ready=1
numero1_o  out  OP_W  committed operand A
numero2_o  out  OP_W  committed operand B
result  out  2*OP_W  latched product
result_valid  out  1  result holds a fresh product
busy  out  1  high in START and WAIT
error  out  1  multiplier timeout flag
state_o  out  3  state code, for debug

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = ENTER_A; accumulator, digit count and edge-detect register cleared.
  - All outputs 0, including numero1_o, numero2_o and result.
- State codes:
  - ENTER_A=0, ENTER_B=1, START=2, WAIT=3, DONE=4, ERR=5.
  - Outputs are Moore/registered.
- Digit entry (ENTER_A and ENTER_B only):
  - On key_valid with a digit d and count < MAX_DIGITS: acc <= acc*10 + d (shift-add), count++.
  - Further digits are ignored once count = MAX_DIGITS.
  - 0xC clears acc and count. Other codes are ignored.
- Commit:
  - Rising edge = dat_ready=1 while the previous sampled value was 0.
  - Operand value = signo ? -acc : acc, OP_W-bit two's complement; -0 = 0.
  - Acc and count clear on commit.
- Transitions:
  - ENTER_A, commit: numero1_o/mult_a <= operand, next state ENTER_B.
  - ENTER_B, commit: numero2_o/mult_b <= operand, next state START.
  - START: mult_start=1 for exactly one cycle, next state WAIT. The timeout counter clears on entry to WAIT.
  - WAIT, mult_ready=1: result <= mult_product, result_valid=1, next state DONE.
  - WAIT, counter reaches TIMEOUT_CYCLES-1 with no ready: error=1, next state ERR.
  - If ready and timeout occur in the same cycle, ready wins.
  - DONE or ERR, commit edge or key 0xC: result_valid=0, error=0, next state ENTER_A. numero1_o/numero2_o/result keep their values until overwritten.
- Ignored inputs:
  - Keys and dat_ready edges in START and WAIT.
  - mult_ready outside WAIT.
  - Digit keys in DONE and ERR.
- Simultaneous key_valid and commit edge in an entry state: commit uses acc before the key; the key is discarded.
- dat_ready held high: exactly one commit. A new commit needs the level to drop to 0 and rise again.
- mult_a and mult_b stay stable from the commit through DONE/ERR.
- Latency:
  - ENTER_B commit edge at clock k → mult_start high in cycle k+1.
  - mult_ready sampled at edge m → result and result_valid updated after edge m.

Test Plan:
1. Keys 4,2, signo=0, commit; keys 1,5, signo=1, commit; model asserts ready 3 cycles after start with 0xFD8A → numero1_o=0x2A, numero2_o=0xF1, mult_start exactly one cycle, result=0xFD8A, result_valid=1, state_o=4.
2. Keys 9,9,7, signo=1, commit → numero1_o=0x9D (-99); the third digit is ignored; state_o=1.
3. Keys 5, 0xC, 3, commit; then dat_ready held high for 50 cycles → numero1_o=0x03; only one state advance occurs.
4. TIMEOUT_CYCLES=16, model never ready → error=1 and state_o=5 exactly 16 cycles after WAIT entry, result_valid=0; next commit edge → state_o=0, error=0.
5. Reset asserted mid-WAIT → all outputs 0 immediately, state_o=0; a mult_ready pulse after release is ignored.
6. Key 7 pulsed and dat_ready rising in the same cycle in ENTER_A with acc=3 → numero1_o=0x03; keys and mult_ready in ENTER_B do not alter result.
